// File: rtl/ins_loader_pkg.sv
// Shared constants for the serial instruction loader.
// Optional checksum trailer: INS_LOADER_CHECKSUM_EN.
package ins_loader_pkg;

   localparam int INS_WORDS = 256;
   localparam int IDX_W     = 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CHK  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/ins_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master = loader side, slave = source / memory side.
interface ins_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/ins_word_pack.sv
// Little-endian byte-lane packer: four accepted bytes form one word.
// word_valid fires combinationally with the fourth byte.
module ins_word_pack
   import ins_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        take,
   input  logic [7:0]  data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [IDX_W-1:0] idx;
   logic [23:0]      lanes;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= '0;
         lanes <= '0;
      end else if (clr) begin
         idx   <= '0;
      end else if (take) begin
         idx <= idx + 1'b1;
         case (idx)
            2'd0:    lanes[7:0]   <= data;
            2'd1:    lanes[15:8]  <= data;
            2'd2:    lanes[23:16] <= data;
            default: ;
         endcase
      end
   end

   assign word_valid = take && (idx == 2'd3);
   assign word       = {data, lanes};

endmodule

// File: rtl/ins_loader.sv
// Serial loader filling instruction memory from a byte stream.
// INS_LOADER_CHECKSUM_EN adds a 32-bit sum trailer check.
module ins_loader
   import ins_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [ADDR_W:0] len,
   ins_loader_if.master    bus,
   output logic            busy,
   output logic            cpu_hold,
   output logic            done,
   output logic            err
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

`ifdef INS_LOADER_CHECKSUM_EN
   localparam logic [1:0] S_AFTER = S_CHK;
`else
   localparam logic [1:0] S_AFTER = S_DONE;
`endif

   logic [1:0]        state;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   len_c;
   logic              take;
   logic              word_valid;
   logic [31:0]       word;

   assign len_c = (len > MAX_LEN) ? MAX_LEN : len;
   assign bus.in_ready = (state == S_LOAD) || (state == S_CHK);
   assign take     = bus.in_valid && bus.in_ready;
   assign busy     = (state != S_IDLE);
   assign cpu_hold = busy;

   ins_word_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .clr        (state == S_IDLE),
      .take       (take),
      .data       (bus.in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         addr          <= '0;
         done          <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  done  <= 1'b0;
                  cnt   <= len_c;
                  addr  <= '0;
                  state <= (len_c == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (word_valid) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_wdata <= word;
                  bus.mem_addr  <= addr;
                  addr          <= addr + 1'b1;
                  cnt           <= cnt - 1'b1;
                  if (cnt == ONE) state <= S_AFTER;
               end
            end
            S_CHK: begin
               if (word_valid) state <= S_DONE;
            end
            default: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef INS_LOADER_CHECKSUM_EN
   logic [31:0] sum;
   logic        bad;
   logic        err_q;

   // Mismatch is latched in CHK and published with done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum   <= '0;
         bad   <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            sum   <= '0;
            bad   <= 1'b0;
            err_q <= 1'b0;
         end
         if (state == S_LOAD && word_valid) sum <= sum + word;
         if (state == S_CHK && word_valid)  bad <= (word != sum);
         if (state == S_DONE) err_q <= bad;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
